// File: rtl/gpio_pad_filt.sv
`default_nettype none
// ============================================================================
//  Module      : gpio_pad_filt
//  Description : GPIO pad front end. Drives each bidirectional pad from its
//                output register when enabled, brings every pad back through
//                a multi-flop synchronizer, optionally rejects glitches with a
//                per-bit stability counter, and produces registered rise/fall
//                strobes. A separate synchronizer carries an external clock
//                pad into the pclk domain with edge strobes.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    WIDTH        number of pad bits
//    SYNC_STAGES  synchronizer depth (2..4)
//    FILT_W       width of filt_len and of each per-bit stability counter
//  Ports
//    pclk           sole clock, rising edge
//    prst           asynchronous active-high reset
//    out_pad_o      per-pad output data
//    oen_padoe_o    per-pad output enable (1 = drive)
//    io_pad         bidirectional pads
//    filt_en        per-bit glitch-filter enable
//    filt_len       stable-cycle count N required by the filter (0 acts as 1)
//    ext_clk_pad_i  external clock pad, asynchronous to pclk
//    in_pad_i       synchronized, filtered pad value
//    in_rise_o      one-cycle strobe when in_pad_i goes 0->1
//    in_fall_o      one-cycle strobe when in_pad_i goes 1->0
//    gpio_eclk      synchronized ext_clk_pad_i level
//    eclk_pe_o      one-cycle strobe on gpio_eclk rising
//    eclk_ne_o      one-cycle strobe on gpio_eclk falling
// ============================================================================
module gpio_pad_filt #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 4
) (
    input  logic              pclk,
    input  logic              prst,
    input  logic [WIDTH-1:0]  out_pad_o,
    input  logic [WIDTH-1:0]  oen_padoe_o,
    inout  wire  [WIDTH-1:0]  io_pad,
    input  logic [WIDTH-1:0]  filt_en,
    input  logic [FILT_W-1:0] filt_len,
    input  logic              ext_clk_pad_i,
    output logic [WIDTH-1:0]  in_pad_i,
    output logic [WIDTH-1:0]  in_rise_o,
    output logic [WIDTH-1:0]  in_fall_o,
    output logic              gpio_eclk,
    output logic              eclk_pe_o,
    output logic              eclk_ne_o
);

    localparam logic [FILT_W:0]   c_one     = {{FILT_W{1'b0}}, 1'b1};
    localparam logic [FILT_W-1:0] c_cnt_one = {{(FILT_W-1){1'b0}}, 1'b1};

    // ------------------------------------------------------------------
    // Pad drivers: purely combinational so reset never disturbs the pads.
    // ------------------------------------------------------------------
    genvar i;
    generate
        for (i = 0; i < WIDTH; i++) begin : g_pad
            assign io_pad[i] = oen_padoe_o[i] ? out_pad_o[i] : 1'bz;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Input synchronizers. Every pad is sampled, including driven ones,
    // so software can read back what is actually on the pin.
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_pad_sync;
    logic [SYNC_STAGES-1:0]            r_eclk_sync;
    logic [WIDTH-1:0]                  w_sync;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_pad_sync  <= '0;
            r_eclk_sync <= '0;
        end else begin
            r_pad_sync  <= {r_pad_sync[SYNC_STAGES-2:0], io_pad};
            r_eclk_sync <= {r_eclk_sync[SYNC_STAGES-2:0], ext_clk_pad_i};
        end
    end

    assign w_sync = r_pad_sync[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // Glitch filter. cnt counts consecutive edges on which the synchronized
    // value disagrees with the filtered value; the filtered value follows
    // once the disagreement has lasted N edges. The compare is one bit
    // wider than the counter so cnt+1 can never wrap.
    // ------------------------------------------------------------------
    logic [FILT_W:0]   w_n;
    logic [WIDTH-1:0]  r_filt;
    logic [FILT_W-1:0] r_cnt [WIDTH];
    logic [WIDTH-1:0]  w_filt_next;
    logic [FILT_W-1:0] w_cnt_next [WIDTH];

    assign w_n = (filt_len == '0) ? c_one : {1'b0, filt_len};

    generate
        for (i = 0; i < WIDTH; i++) begin : g_filt
            logic w_diff;
            logic w_hit;

            assign w_diff = filt_en[i] && (w_sync[i] != r_filt[i]);
            assign w_hit  = (({1'b0, r_cnt[i]} + c_one) >= w_n);

            // Bypass follows sync directly; filtered bits move only on a hit.
            assign w_filt_next[i] = !filt_en[i]        ? w_sync[i] :
                                    (w_diff && w_hit)  ? w_sync[i] :
                                                         r_filt[i];
            assign w_cnt_next[i]  = (w_diff && !w_hit) ? (r_cnt[i] + c_cnt_one) : '0;
        end
    endgenerate

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            r_filt    <= '0;
            in_rise_o <= '0;
            in_fall_o <= '0;
            for (int b = 0; b < WIDTH; b++) begin
                r_cnt[b] <= '0;
            end
        end else begin
            r_filt    <= w_filt_next;
            // Strobes are registered from the next-state so they coincide
            // with the cycle in which in_pad_i shows the new level.
            in_rise_o <= w_filt_next & ~r_filt;
            in_fall_o <= ~w_filt_next & r_filt;
            for (int b = 0; b < WIDTH; b++) begin
                r_cnt[b] <= w_cnt_next[b];
            end
        end
    end

    assign in_pad_i = r_filt;

    // ------------------------------------------------------------------
    // External clock edge strobes, coincident with the gpio_eclk change.
    // ------------------------------------------------------------------
    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            eclk_pe_o <= 1'b0;
            eclk_ne_o <= 1'b0;
        end else begin
            eclk_pe_o <= r_eclk_sync[SYNC_STAGES-2] & ~r_eclk_sync[SYNC_STAGES-1];
            eclk_ne_o <= ~r_eclk_sync[SYNC_STAGES-2] & r_eclk_sync[SYNC_STAGES-1];
        end
    end

    assign gpio_eclk = r_eclk_sync[SYNC_STAGES-1];

endmodule
`default_nettype wire
